// File: rtl/muxpga_cfg_loader_if.sv
// Host command bus and fabric configuration-chain signals of the mux-FPGA loader.
// The host drives cmd/nibble; the loader drives the chain and status outputs.
interface muxpga_cfg_loader_if;
    logic [1:0] cmd;
    logic [3:0] nibble;
    logic       cfg_data;
    logic       cfg_shift;
    logic       cfg_valid;
    logic       busy;
    logic       err;

    modport master (
        output cmd, nibble,
        input  cfg_data, cfg_shift, cfg_valid, busy, err
    );

    modport slave (
        input  cmd, nibble,
        output cfg_data, cfg_shift, cfg_valid, busy, err
    );
endinterface

// File: rtl/muxpga_cfg_loader.sv
// Nibble-wide configuration loader serialising host data into the mux-FPGA chain.
// Optional macro MUXPGA_CFG_CHECKSUM_EN adds an XOR checksum check on COMMIT.
module muxpga_cfg_loader #(
    parameter int CFG_BITS = 64
) (
    input  logic clk,
    input  logic rst_n,
    muxpga_cfg_loader_if.slave bus
);
    localparam int NIBBLES = CFG_BITS / 4;
    localparam int CW      = $clog2(NIBBLES + 1);
    localparam logic [CW-1:0] NIB_MAX = CW'(NIBBLES);

    localparam logic [1:0] CMD_IDLE   = 2'b00;
    localparam logic [1:0] CMD_LOAD   = 2'b01;
    localparam logic [1:0] CMD_COMMIT = 2'b10;
    localparam logic [1:0] CMD_CLEAR  = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    logic [1:0]    cmd_meta_reg, cmd_s_reg, cmd_q_reg;
    logic [3:0]    nib_meta_reg, nib_s_reg;
    logic          strobe_reg;
    logic [1:0]    strobe_cmd_reg;
    state_t        state_reg;
    logic [CW-1:0] count_reg;
    logic [3:0]    shift_nib_reg;
    logic [1:0]    bit_idx_reg;
    logic          cfg_data_reg, cfg_shift_reg, cfg_valid_reg, busy_reg, err_reg;
    logic          chk_ok;
    logic          load_ok;
    logic          clear_fire;

    // Synchronisers plus a registered edge strobe: an action lands three edges after the pin is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_meta_reg   <= CMD_IDLE;
            cmd_s_reg      <= CMD_IDLE;
            cmd_q_reg      <= CMD_IDLE;
            nib_meta_reg   <= 4'h0;
            nib_s_reg      <= 4'h0;
            strobe_reg     <= 1'b0;
            strobe_cmd_reg <= CMD_IDLE;
        end else begin
            cmd_meta_reg   <= bus.cmd;
            cmd_s_reg      <= cmd_meta_reg;
            cmd_q_reg      <= cmd_s_reg;
            nib_meta_reg   <= bus.nibble;
            nib_s_reg      <= nib_meta_reg;
            strobe_reg     <= (cmd_s_reg != CMD_IDLE) && (cmd_q_reg == CMD_IDLE);
            strobe_cmd_reg <= cmd_s_reg;
        end
    end

    assign load_ok    = strobe_reg && (strobe_cmd_reg == CMD_LOAD) && (state_reg == ST_IDLE)
                        && (count_reg < NIB_MAX) && !cfg_valid_reg;
    assign clear_fire = strobe_reg && (strobe_cmd_reg == CMD_CLEAR);

`ifdef MUXPGA_CFG_CHECKSUM_EN
    logic [3:0] chk_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_reg <= 4'h0;
        end else if (clear_fire) begin
            chk_reg <= 4'h0;
        end else if (load_ok) begin
            chk_reg <= chk_reg ^ nib_s_reg;
        end
    end

    assign chk_ok = (nib_s_reg == chk_reg);
`else
    assign chk_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            shift_nib_reg <= 4'h0;
            bit_idx_reg   <= 2'd0;
            cfg_data_reg  <= 1'b0;
            cfg_shift_reg <= 1'b0;
            cfg_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (strobe_reg) begin
                        case (strobe_cmd_reg)
                            CMD_LOAD: begin
                                if (load_ok) begin
                                    shift_nib_reg <= nib_s_reg;
                                    count_reg     <= count_reg + 1'b1;
                                    bit_idx_reg   <= 2'd0;
                                    cfg_data_reg  <= nib_s_reg[0];
                                    cfg_shift_reg <= 1'b1;
                                    busy_reg      <= 1'b1;
                                    state_reg     <= ST_SHIFT;
                                end else begin
                                    err_reg <= 1'b1;
                                end
                            end
                            CMD_COMMIT: begin
                                if ((count_reg == NIB_MAX) && chk_ok) begin
                                    cfg_valid_reg <= 1'b1;
                                    state_reg     <= ST_DONE;
                                end else begin
                                    err_reg <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_SHIFT: begin
                    // bit_idx_reg names the bit currently on cfg_data.
                    if (bit_idx_reg == 2'd3) begin
                        cfg_data_reg  <= 1'b0;
                        cfg_shift_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end else begin
                        bit_idx_reg  <= bit_idx_reg + 2'd1;
                        cfg_data_reg <= shift_nib_reg[bit_idx_reg + 2'd1];
                    end
                    if (strobe_reg && !clear_fire) begin
                        err_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (strobe_reg && ((strobe_cmd_reg == CMD_LOAD) || (strobe_cmd_reg == CMD_COMMIT))) begin
                        err_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            // CLEAR wins from any state, aborting a shift in progress; chain contents are untouched.
            if (clear_fire) begin
                count_reg     <= '0;
                err_reg       <= 1'b0;
                cfg_valid_reg <= 1'b0;
                cfg_shift_reg <= 1'b0;
                cfg_data_reg  <= 1'b0;
                busy_reg      <= 1'b0;
                state_reg     <= ST_IDLE;
            end
        end
    end

    assign bus.cfg_data  = cfg_data_reg;
    assign bus.cfg_shift = cfg_shift_reg;
    assign bus.cfg_valid = cfg_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.err       = err_reg;
endmodule

// File: doc/muxpga_cfg_loader.md
# muxpga_cfg_loader

Configuration loader that sits directly upstream of the differential mux-FPGA fabric. It accepts a configuration bitstream from the host one nibble at a time over the chip's pin-level command interface (`cmd[1:0]` plus a 4-bit data nibble). It serialises each nibble into the fabric's configuration shift chain. On commit it validates the load and raises `cfg_valid`, which enables the fabric.

## Interface

Parameters:
- `CFG_BITS`, default 64. Total configuration chain length. Must be a multiple of 4 and ≥ 4. `NIBBLES = CFG_BITS/4`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd`  in  2  host command, asynchronous to `clk`: 00 IDLE, 01 LOAD, 10 COMMIT, 11 CLEAR.
- `nibble`  in  4  host data, asynchronous to `clk`. It is the payload for LOAD and the checksum for COMMIT.
- `cfg_data`  out  1  serial bit to the fabric chain.
- `cfg_shift`  out  1  chain shift enable. The fabric samples `cfg_data` on each `clk` edge where `cfg_shift`=1.
- `cfg_valid`  out  1  configuration committed; fabric enabled.
- `busy`  out  1  a nibble is being shifted.
- `err`  out  1  sticky error flag.

## Operation

- `cmd` and `nibble` each pass through a 2-flop synchroniser, giving `cmd_s` and `nib_s`. `cmd_q` is `cmd_s` delayed by one cycle.
- A command strobe fires when `cmd_s`≠00 and `cmd_q`=00.
  - A held command executes exactly once.
  - Switching directly between two non-IDLE codes is not a strobe.
- The host holds `nibble` stable from at least 3 cycles before `cmd` leaves 00 until `cmd` returns to 00.
- FSM states: IDLE, SHIFT, DONE.
  - **IDLE, LOAD, count < NIBBLES, `cfg_valid`=0:** latch `nib_s`, XOR it into the `chk` register, increment `count`, go to SHIFT.
  - **IDLE, LOAD, any other condition:** set `err`. Nothing is shifted and state is unchanged. This covers overflow and LOAD after commit.
  - **SHIFT:** drive `cfg_shift`=1 for exactly 4 cycles, `cfg_data` = latched nibble bit 0, 1, 2, 3 in that order. Then return to IDLE.
  - **IDLE, COMMIT:** if count = NIBBLES and the checksum passes (see Configuration), set `cfg_valid`=1 and go to DONE. Otherwise set `err` and stay in IDLE.
  - **DONE:** LOAD or COMMIT sets `err` and is otherwise ignored.
  - **CLEAR, any state:** clear `count`, `chk`, `err` and `cfg_valid`, and go to IDLE. The chain contents are left as-is.
  - **A strobe that arrives in SHIFT:** ignored and sets `err`. This is only reachable through host protocol violation.
- `busy` = (state == SHIFT).
- `count` is $clog2(NIBBLES+1) bits wide and never wraps; overflow is prevented by the LOAD rule.
- `chk` is 4 bits wide.

## Timing

- Every output is registered.
- Reset value of every output is 0. Internal state is also reset: `count`=0, `chk`=0, FSM in IDLE, synchroniser and `cmd_q` flops 0.
- Latency from a pin change sampled at edge k:
  - the strobe is evaluated after edge k+2;
  - first `cfg_shift`=1 is in the cycle following edge k+3;
  - `cfg_shift` is high for 4 consecutive cycles;
  - `busy` is high for the same 4 cycles.
- COMMIT and CLEAR take effect one cycle after the strobe, so `cfg_valid` and `err` update after edge k+3.
- `err` is set in the cycle after the offending strobe and stays high until CLEAR or reset.
- Async reset mid-SHIFT:
  - `cfg_shift` and `cfg_data` drop to 0 immediately;
  - the partial nibble is lost;
  - the host must CLEAR and reload.
- Minimum host command period: one command, then IDLE for ≥ 7 cycles, before the next command.

## Configuration

- Macro `MUXPGA_CFG_CHECKSUM_EN`.
- **Defined:** COMMIT passes only if `nib_s` == XOR of all loaded nibbles (`chk`). A mismatch sets `err` and leaves `cfg_valid`=0.
- **Undefined:** the `chk` register is not built, `nibble` is ignored on COMMIT, and COMMIT passes whenever count = NIBBLES.

## Test plan

- **Reset:** assert `rst_n`=0 with random `cmd`/`nibble` → all outputs 0. Release → all outputs remain 0 until a command.
- **Good load (`CFG_BITS`=8, checksum on):** LOAD 0xA, LOAD 0x5, COMMIT 0xF →
  - `cfg_data` on the shift cycles = 0,1,0,1,1,0,1,0;
  - exactly 8 `cfg_shift` pulses;
  - `cfg_valid`=1, `err`=0.
- **Bad checksum:** same loads, COMMIT 0x3 → `err`=1, `cfg_valid`=0. Then CLEAR → `err`=0.
- **Overflow / early commit (`CFG_BITS`=8):**
  - COMMIT after one LOAD → `err`=1, `cfg_valid`=0.
  - CLEAR, load two nibbles, then a third LOAD 0x7 → `err`=1 and no `cfg_shift` pulses for the third LOAD.
- **Held command:** hold `cmd`=01, `nibble`=0x3 for 20 cycles → exactly 4 `cfg_shift` pulses, `cfg_data` 1,1,0,0, `busy` high for 4 cycles.
- **Reset mid-shift:** LOAD 0xF, assert `rst_n`=0 on the 2nd shift cycle → `cfg_shift`=0 immediately. After release, a new COMMIT sets `err` because count=0.
